// File: rtl/timer_array_apb.sv
// timer_array_apb: NUM_CH prescaled up/down counters with flags and irqs behind an APB-style slave.
// Latency: one wait state per transfer; writes commit on the pready edge, LOAD lands one clock later.
// Backpressure: none beyond the fixed wait state; TIMER_AUTO_RELOAD_EN reloads TCNT from TDR on wrap.
module timer_array_apb #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [CNT_W-1:0]  pwdata,
    output logic [CNT_W-1:0]  prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] irq
);
    logic [CNT_W-1:0]  tdr  [NUM_CH];
    logic [CNT_W-1:0]  tcnt [NUM_CH];
    logic [2:0]        cks  [NUM_CH];
    logic [NUM_CH-1:0] en, dir, ovie, udie, ovf, udf, load_pend;
    logic [7:0]        div;

    logic              commit, legal, err;
    logic [3:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic [CNT_W-1:0]  rd_val;
    logic [NUM_CH-1:0] tick, set_ov, set_ud, wr_tdr, wr_tcr, wr_tsr;

    // pready doubles as the "already acknowledged" marker so one access phase commits once
    assign commit  = psel & penable & ~pready;
    assign legal   = {24'd0, paddr} < 32'(4 * NUM_CH);
    assign ch_sel  = paddr[5:2];
    assign reg_sel = paddr[1:0];
    assign err     = ~legal | (pwrite & (reg_sel == 2'd3));

    always_comb begin
        tick   = '0;
        set_ov = '0;
        set_ud = '0;
        wr_tdr = '0;
        wr_tcr = '0;
        wr_tsr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            tick[c]   = en[c] & (&(div | ~(8'hff >> (3'd7 - cks[c]))));
            set_ov[c] = tick[c] & ~load_pend[c] & ~dir[c] & (tcnt[c] == '1);
            set_ud[c] = tick[c] & ~load_pend[c] &  dir[c] & (tcnt[c] == '0);
            wr_tdr[c] = commit & pwrite & ~err & (ch_sel == 4'(c)) & (reg_sel == 2'd0);
            wr_tcr[c] = commit & pwrite & ~err & (ch_sel == 4'(c)) & (reg_sel == 2'd1);
            wr_tsr[c] = commit & pwrite & ~err & (ch_sel == 4'(c)) & (reg_sel == 2'd2);
        end
    end

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 4'(c)) begin
                case (reg_sel)
                    2'd0:    rd_val = tdr[c];
                    2'd1:    rd_val = CNT_W'({udie[c], ovie[c], cks[c], 1'b0, dir[c], en[c]});
                    2'd2:    rd_val = CNT_W'({udf[c], ovf[c]});
                    default: rd_val = tcnt[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
            en        <= '0;
            dir       <= '0;
            ovie      <= '0;
            udie      <= '0;
            ovf       <= '0;
            udf       <= '0;
            load_pend <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                tdr[c]  <= '0;
                tcnt[c] <= '0;
                cks[c]  <= '0;
            end
        end else begin
            div     <= div + 8'd1;
            pready  <= commit;
            pslverr <= commit & err;
            prdata  <= (commit & ~err & ~pwrite) ? rd_val : '0;
            for (int c = 0; c < NUM_CH; c++) begin
                load_pend[c] <= wr_tcr[c] & pwdata[2];
                if (wr_tdr[c]) begin
                    tdr[c] <= pwdata;
                end
                if (wr_tcr[c]) begin
                    en[c]   <= pwdata[0];
                    dir[c]  <= pwdata[1];
                    cks[c]  <= pwdata[5:3];
                    ovie[c] <= pwdata[6];
                    udie[c] <= pwdata[7];
                end
                // a freshly raised flag beats a W1C landing on the same edge
                ovf[c] <= set_ov[c] | (ovf[c] & ~(wr_tsr[c] & pwdata[0]));
                udf[c] <= set_ud[c] | (udf[c] & ~(wr_tsr[c] & pwdata[1]));
                if (load_pend[c]) begin
                    tcnt[c] <= tdr[c];
`ifdef TIMER_AUTO_RELOAD_EN
                end else if (set_ov[c] | set_ud[c]) begin
                    tcnt[c] <= tdr[c];
`endif
                end else if (tick[c]) begin
                    tcnt[c] <= dir[c] ? tcnt[c] - 1'b1 : tcnt[c] + 1'b1;
                end
            end
        end
    end

    assign irq = (ovf & ovie) | (udf & udie);

endmodule

// File: tb/tb_timer_array_apb.sv
// Randomised + directed bench for timer_array_apb: a cycle model fills a scoreboard that a
// separate negedge monitor drains whenever the slave raises pready.
module tb_timer_array_apb;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int MAXV   = (1 << CNT_W) - 1;
`ifdef TIMER_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, psel, penable, pwrite;
    logic [7:0]        paddr;
    logic [CNT_W-1:0]  pwdata, prdata;
    logic              pready, pslverr;
    logic [NUM_CH-1:0] irq;

    timer_array_apb #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct { int rdata; bit err; } exp_t;
    exp_t q[$];

    int m_tdr[NUM_CH], m_tcr[NUM_CH], m_cnt[NUM_CH];
    bit m_ovf[NUM_CH], m_udf[NUM_CH], m_loadp[NUM_CH];
    int m_n;
    bit m_ack;
    int mc, mr, per, ncnt;
    bit m_commit, m_err, tk, s_ov, s_ud, clr_ov, clr_ud, nlp;
    exp_t e;

    function automatic int reg_val(input int c, input int r);
        case (r)
            0:       return m_tdr[c];
            1:       return m_tcr[c];
            2:       return int'(m_ovf[c]) + 2 * int'(m_udf[c]);
            default: return m_cnt[c];
        endcase
    endfunction

    function automatic logic [NUM_CH-1:0] model_irq();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++)
            v[c] = (m_ovf[c] && (m_tcr[c] & 'h40) != 0) || (m_udf[c] && (m_tcr[c] & 'h80) != 0);
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_tdr[c] = 0; m_tcr[c] = 0; m_cnt[c] = 0;
                m_ovf[c] = 0; m_udf[c] = 0; m_loadp[c] = 0;
            end
            m_n = 0;
            m_ack = 0;
        end else begin
            m_commit = psel && penable && !m_ack;
            mc = int'(paddr) / 4;
            mr = int'(paddr) % 4;
            m_err = (int'(paddr) >= 4 * NUM_CH) || (pwrite && mr == 3);
            if (m_commit) begin
                e.err = m_err;
                e.rdata = (m_err || pwrite) ? 0 : reg_val(mc, mr);
                q.push_back(e);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                per = 2 << ((m_tcr[c] >> 3) & 7);
                tk = (m_tcr[c] & 1) != 0 && (m_n % per == per - 1);
                s_ov = 0; s_ud = 0; ncnt = m_cnt[c];
                if (m_loadp[c]) ncnt = m_tdr[c];
                else if (tk) begin
                    if ((m_tcr[c] & 2) != 0) begin
                        if (m_cnt[c] == 0) begin s_ud = 1; ncnt = AR ? m_tdr[c] : MAXV; end
                        else ncnt = m_cnt[c] - 1;
                    end else begin
                        if (m_cnt[c] == MAXV) begin s_ov = 1; ncnt = AR ? m_tdr[c] : 0; end
                        else ncnt = m_cnt[c] + 1;
                    end
                end
                nlp = 0; clr_ov = 0; clr_ud = 0;
                if (m_commit && pwrite && !m_err && mc == c) begin
                    case (mr)
                        0: m_tdr[c] = int'(pwdata);
                        1: begin m_tcr[c] = int'(pwdata) & 'hFB; nlp = pwdata[2]; end
                        2: begin clr_ov = pwdata[0]; clr_ud = pwdata[1]; end
                        default: ;
                    endcase
                end
                m_cnt[c]   = ncnt;
                m_loadp[c] = nlp;
                m_ovf[c]   = (m_ovf[c] && !clr_ov) || s_ov;
                m_udf[c]   = (m_udf[c] && !clr_ud) || s_ud;
            end
            m_n++;
            m_ack = m_commit;
        end
    end

    // ---------------- monitor ----------------
    bit prev_pready = 0;
    exp_t got;
    always @(negedge clk) begin
        if (pready === 1'b1) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_pready", 1, 0);
            end else begin
                got = q.pop_front();
                chk("sb_prdata", prdata, got.rdata);
                chk("sb_pslverr", pslverr, got.err);
            end
            chk("pready_one_cycle", prev_pready, 0);
        end else begin
            chk("prdata_idle", prdata, 0);
        end
        chk("irq", irq, model_irq());
        prev_pready = (pready === 1'b1);
    end

    // ---------------- stimulus ----------------
    task automatic apb(input bit wr, input logic [7:0] a, input logic [CNT_W-1:0] d,
                       output logic [CNT_W-1:0] rd, output logic er);
        int waits;
        @(negedge clk);
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (pready !== 1'b1 && waits < 10);
        chk("wait_states", waits, 1);
        rd = prdata;
        er = pslverr;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    logic [CNT_W-1:0] v, v0;
    logic             er;

    task automatic wr(input logic [7:0] a, input logic [CNT_W-1:0] d);
        apb(1'b1, a, d, v, er);
    endtask

    task automatic rd(input logic [7:0] a);
        apb(1'b0, a, '0, v, er);
    endtask

    initial begin
        rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        repeat (2) @(negedge clk);
        rst = 0;

        for (int a = 0; a < 4 * NUM_CH; a++) begin
            rd(8'(a));
            chk("reset_reg", v, 0);
        end

        for (int c = 0; c < NUM_CH; c++) begin
            wr(8'(4 * c), 8'hA5 ^ 8'(c));
            rd(8'(4 * c));
            chk("tdr_rw", v, 8'hA5 ^ 8'(c));
            chk("tdr_rw_err", er, 0);
        end
        wr(8'h04, 8'hA5);
        rd(8'h04);
        chk("tdr_a5", v, 8'hA5);

        // load while disabled, then up-count overflow on ch0
        wr(8'h00, 8'hFD);
        wr(8'h01, 8'h44);
        rd(8'h03);
        chk("load_frozen", v, 8'hFD);
        wr(8'h01, 8'h45);
        repeat (20) @(negedge clk);
        chk("ovf_irq0", irq[0], 1);
        rd(8'h02);
        chk("ovf_tsr", v, 8'h01);
        wr(8'h02, 8'h01);
        rd(8'h02);
        chk("ovf_w1c", v, 8'h00);
        chk("ovf_irq0_clr", irq[0], 0);
        wr(8'h01, 8'h00);

        // down-count underflow on ch1
        wr(8'h04, 8'h01);
        wr(8'h05, 8'h87);
        repeat (10) @(negedge clk);
        rd(8'h06);
        chk("udf_tsr", v, 8'h02);
        chk("udf_irq1", irq[1], 1);
        chk("udf_irq0", irq[0], 0);
        wr(8'h05, 8'h00);
        wr(8'h06, 8'h02);

        // errors
        rd(8'h10);
        chk("err_rd_slverr", er, 1);
        chk("err_rd_data", v, 0);
        rd(8'h03);
        v0 = v;
        wr(8'h03, 8'h55);
        chk("err_wr_slverr", er, 1);
        rd(8'h03);
        chk("err_tcnt_kept", v, v0);

`ifdef TIMER_AUTO_RELOAD_EN
        wr(8'h00, 8'hFE);
        wr(8'h01, 8'h05);
        repeat (12) @(negedge clk);
        rd(8'h02);
        chk("ar_ovf", v, 8'h01);
        rd(8'h03);
        chk("ar_range", (v >= 8'hFE), 1);
        wr(8'h01, 8'h00);
`endif

        // reset in the middle of counting
        wr(8'h00, 8'h10);
        wr(8'h01, 8'hC5);
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_irq", irq, 0);
        repeat (10) @(negedge clk);
        for (int a = 0; a < 4 * NUM_CH; a++) begin
            rd(8'(a));
            chk("rst_mid_reg", v, 0);
        end

        // randomised traffic, checked via the scoreboard
        for (int i = 0; i < 250; i++) begin
            logic [7:0] a;
            logic [CNT_W-1:0] d;
            a = 8'($urandom_range(0, 4 * NUM_CH + 2));
            d = CNT_W'($urandom);
            if (a[1:0] == 2'd1 && $urandom_range(0, 1) == 1) d[5:3] = 3'($urandom_range(0, 1));
            apb(1'($urandom_range(0, 1)), a, d, v, er);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
